parser_ingress_arb: RTL
=======================

# parser_ingress_arb

Round-robin arbiter that shares the single header `parser` among `N_PORTS` ingress packet streams. Each stream carries 512-bit flits plus one `metadata_t` per packet. The arbiter selects one requester per packet and holds the grant until that packet's eop flit has transferred. It forwards flits and the packet's metadata through one registered output stage into the parser's `in_pkt_*` / `in_meta_*` interface.

## Interface
Parameters:
- `N_PORTS`, default 4: number of ingress requesters, 2..8.
- `PTR_W`, default `$clog2(N_PORTS)`: width of the grant index and round-robin pointer.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_pkt_data` in `N_PORTS*512`: flit data, port i at `[i*512 +: 512]`.
- `in_pkt_valid`, `in_pkt_sop`, `in_pkt_eop` in `N_PORTS`: per-port flit qualifiers.
- `in_pkt_empty` in `N_PORTS*6`: empty bytes per port.
- `in_pkt_ready` out `N_PORTS`: per-port flit accept.
- `in_meta_data` in `N_PORTS` x `metadata_t`: per-port packet metadata.
- `in_meta_valid` in `N_PORTS`: metadata present.
- `in_meta_ready` out `N_PORTS`: metadata accept.
- `out_pkt_data` out 512, `out_pkt_valid` out 1, `out_pkt_sop` out 1, `out_pkt_eop` out 1, `out_pkt_empty` out 6: flit stream to the parser.
- `out_pkt_ready` in 1: parser flit accept.
- `out_meta_data` out `metadata_t`, `out_meta_valid` out 1: metadata to the parser.
- `out_meta_ready` in 1: parser metadata accept.
- `grant_idx` out `PTR_W`: port currently locked, or last winner.
- `locked` out 1: high while a multi-flit packet is in progress.
- `stat_pkts` out `N_PORTS*32`: per-port forwarded packet count. Driven only when `ARB_STATS_EN` is defined (see Configuration).

## Operation
- States:
  - IDLE: no packet in progress.
  - LOCKED: a multi-flit packet from port `grant_idx` is in progress.
- Eligibility of port i: `in_pkt_valid[i] & in_pkt_sop[i] & in_meta_valid[i]`.
  - A valid non-sop flit at a port's head in IDLE is ineligible. It waits; framing is upstream's responsibility.
- Selection in IDLE:
  - The winner is the first eligible port scanning from `rr_ptr` upward, modulo `N_PORTS`. This is combinational.
  - `in_pkt_ready[w] = in_meta_ready[w] = slot_free`. All other readies are 0.
- Slot and output fire:
  - `slot_free = ~out_pkt_valid | out_fire`.
  - `out_fire = out_pkt_valid & out_pkt_ready & (~out_meta_valid | out_meta_ready)`.
- Transitions on an accepted sop flit from port w:
  - eop=1: stay IDLE, `rr_ptr <= w+1` (mod `N_PORTS`).
  - eop=0: go to LOCKED, `grant_idx <= w`.
- In LOCKED:
  - Only port g gets `in_pkt_ready[g] = slot_free`. `in_meta_ready` is 0 for all ports.
  - The sop bit on continuation flits is forwarded unmodified.
  - An accepted flit with eop=1 returns the block to IDLE with `rr_ptr <= g+1`.
- Output register:
  - On accept, the flit fields are captured.
  - `out_meta_valid` is set together with `out_pkt_valid` only on the sop flit, and `out_meta_data` is captured then.
  - Both valids clear on `out_fire` unless a new flit is captured in the same cycle.
- Simultaneous fire and accept: `out_fire` and a new accept in the same cycle loads the new flit. There is no bubble.
- Metadata is passed through unmodified. `pktID` and `flits` are not rewritten.

## Timing
- Latency: 1 cycle from accept at the input to `out_pkt_valid`.
- Throughput: back-to-back single-flit packets from different ports sustain 1 packet/cycle when `out_*_ready` is held high.
- Reset (`rst_n` low at a clk edge):
  - State IDLE; `rr_ptr = 0`; `grant_idx = 0`; `locked = 0`.
  - `out_pkt_valid`, `out_meta_valid`, `out_pkt_sop`, `out_pkt_eop` are 0; `out_pkt_empty = 0`.
  - All `in_*_ready` are 0 while `rst_n` is low. `stat_pkts` = 0.
- Reset mid-packet: the partial packet is abandoned, and the output register is discarded.
- Output stall: all output fields hold stable while `out_pkt_valid & ~out_fire`.
- Pointer wrap: from port `N_PORTS-1`, `rr_ptr` wraps to 0.

## Configuration
- `ARB_STATS_EN` defined:
  - `stat_pkts[i*32 +: 32]` increments on each accepted eop flit from port i.
  - Counters wrap at 2^32 and are cleared by reset.
- `ARB_STATS_EN` undefined: `stat_pkts` is tied to 0 and no counter registers exist.

## Test plan
- Single-flit packets: ports 0..3 each present one sop=eop=1 flit at cycle 0 with `out_*_ready` = 1.
  - Required: outputs in port order 0,1,2,3 on cycles 1..4, each with its own `out_meta_valid`/`out_meta_data`.
- Lock across a multi-flit packet: port 1 sends a 3-flit packet while port 2 is eligible the whole time.
  - Required: port 1's 3 flits are output contiguously, then port 2's packet. `locked` is 1 for exactly 2 cycles.
- Output backpressure: deassert `out_meta_ready` for 4 cycles while an sop flit is pending.
  - Required: output fields stable, all `in_pkt_ready` = 0, and no flit is lost or duplicated after release.
- Fairness: ports 0 and 3 are continuously eligible with single-flit packets for 8 packets.
  - Required: grants alternate 0,3,0,3,…
- Mid-packet reset: drive `rst_n` = 0 after flit 2 of a 4-flit packet.
  - Required: next cycle `out_pkt_valid` = 0, `locked` = 0, `rr_ptr` = 0, and the next sop is arbitrated normally.
- With `ARB_STATS_EN`: forward 5 packets from port 2.
  - Required: `stat_pkts` for port 2 = 5 and all other ports 0. Without the macro, all counts read 0.

Source files
------------

// File: rtl/parser_ingress_arb.sv
// parser_ingress_arb: round-robin arbiter sharing the header parser among N_PORTS ingress packet streams
// Ports: clk; rst_n (synchronous, active-low); in_pkt_* and in_meta_* carry per-port
// flits and packet metadata, with in_pkt_ready/in_meta_ready as the per-port accepts;
// out_pkt_* and out_meta_* form the registered stream to the parser; grant_idx and
// locked report arbitration status; stat_pkts holds per-port packet counts.
// metadata_t travels as a flat META_W-bit vector {pktID, flits} and is never rewritten.
// Optional feature: define ARB_STATS_EN to build the stat_pkts counters (tied to 0 otherwise).
module parser_ingress_arb #(
  parameter int N_PORTS = 4,
  parameter int PTR_W   = $clog2(N_PORTS),
  parameter int META_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PORTS*512-1:0]    in_pkt_data,
  input  logic [N_PORTS-1:0]        in_pkt_valid,
  input  logic [N_PORTS-1:0]        in_pkt_sop,
  input  logic [N_PORTS-1:0]        in_pkt_eop,
  input  logic [N_PORTS*6-1:0]      in_pkt_empty,
  output logic [N_PORTS-1:0]        in_pkt_ready,
  input  logic [N_PORTS*META_W-1:0] in_meta_data,
  input  logic [N_PORTS-1:0]        in_meta_valid,
  output logic [N_PORTS-1:0]        in_meta_ready,
  output logic [511:0]              out_pkt_data,
  output logic                      out_pkt_valid,
  output logic                      out_pkt_sop,
  output logic                      out_pkt_eop,
  output logic [5:0]                out_pkt_empty,
  input  logic                      out_pkt_ready,
  output logic [META_W-1:0]         out_meta_data,
  output logic                      out_meta_valid,
  input  logic                      out_meta_ready,
  output logic [PTR_W-1:0]          grant_idx,
  output logic                      locked,
  output logic [N_PORTS*32-1:0]     stat_pkts
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [PTR_W-1:0] rr_ptr, win, scan, sel, nxt;
  logic [N_PORTS-1:0] elig, sel_oh;
  logic any, idle, out_fire, slot_free, grant_ok, accept;
  assign idle = (state == IDLE);
  assign locked = ~idle;
  assign elig = in_pkt_valid & in_pkt_sop & in_meta_valid;
  // scan downward so the last hit, i.e. the first eligible port at or after rr_ptr, wins
  always_comb begin
    win = '0;
    any = 1'b0;
    scan = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      scan = PTR_W'((int'(rr_ptr) + k) % N_PORTS);
      if (elig[scan]) begin
        win = scan;
        any = 1'b1;
      end
    end
  end
  assign sel = idle ? win : grant_idx;
  assign nxt = (sel == PTR_W'(N_PORTS - 1)) ? '0 : sel + 1'b1;
  assign sel_oh = N_PORTS'(1) << sel;
  assign out_fire = out_pkt_valid & out_pkt_ready & (~out_meta_valid | out_meta_ready);
  assign slot_free = ~out_pkt_valid | out_fire;
  assign grant_ok = rst_n & slot_free & (~idle | any);
  assign in_pkt_ready = grant_ok ? sel_oh : '0;
  assign in_meta_ready = (grant_ok & idle) ? sel_oh : '0;
  assign accept = grant_ok & in_pkt_valid[sel];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_idx <= '0;
      out_pkt_valid <= 1'b0;
      out_meta_valid <= 1'b0;
      out_pkt_sop <= 1'b0;
      out_pkt_eop <= 1'b0;
      out_pkt_empty <= '0;
    end else if (accept) begin
      out_pkt_valid <= 1'b1;
      out_meta_valid <= idle;
      out_pkt_data <= in_pkt_data[sel*512 +: 512];
      out_pkt_sop <= in_pkt_sop[sel];
      out_pkt_eop <= in_pkt_eop[sel];
      out_pkt_empty <= in_pkt_empty[sel*6 +: 6];
      if (idle) begin
        out_meta_data <= in_meta_data[sel*META_W +: META_W];
        grant_idx <= sel;
      end
      state <= in_pkt_eop[sel] ? IDLE : LOCKED;
      rr_ptr <= in_pkt_eop[sel] ? nxt : rr_ptr;
    end else if (out_fire) begin
      out_pkt_valid <= 1'b0;
      out_meta_valid <= 1'b0;
    end
  end
`ifdef ARB_STATS_EN
  logic [31:0] cnt [N_PORTS];
  always_ff @(posedge clk) begin
    if (!rst_n)
      for (int i = 0; i < N_PORTS; i++) cnt[i] <= '0;
    else if (accept & in_pkt_eop[sel])
      cnt[sel] <= cnt[sel] + 32'd1;
  end
  for (genvar i = 0; i < N_PORTS; i++) begin : g_stat
    assign stat_pkts[i*32 +: 32] = cnt[i];
  end
`else
  assign stat_pkts = '0;
`endif
endmodule
